// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive sides.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } t_tx_state;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter; dout shows the head entry.
module uart_tx_fifo
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  // Pushes into a full FIFO are dropped even when a pop frees a slot on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  // The extra pointer bit separates the full and empty cases when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout  = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: drains the TX FIFO as back-to-back 8N1 frames on tx_serial.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] UART_CPB,
  input  logic [7:0]  UART_TDR,
  input  logic        tx_wr,
  output logic        tx_full,
  output logic        tx_busy,
  output logic        tx_serial,
  output logic        tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  t_tx_state   state_q, state_d;
  logic [15:0] cntr_q, cntr_d;
  logic [15:0] cpb_q, cpb_d;
  logic [2:0]  bitcntr_q, bitcntr_d;
  logic [7:0]  shift_q, shift_d;
  logic        serial_q, serial_d;
  logic        done_q, done_d;
  logic        load, bit_end;
  logic        fifo_empty, fifo_full;
  logic [7:0]  fifo_dout;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_wr),
    .pop   (load),
    .din   (UART_TDR),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cntr_q    <= '0;
      cpb_q     <= '0;
      bitcntr_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cntr_q    <= cntr_d;
      cpb_q     <= cpb_d;
      bitcntr_q <= bitcntr_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
    end
  end

  assign bit_end = (cntr_q == cpb_q);

  always_comb begin
    state_d   = state_q;
    cntr_d    = cntr_q;
    cpb_d     = cpb_q;
    bitcntr_d = bitcntr_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
    load      = 1'b0;

    if (state_q != S_IDLE) cntr_d = bit_end ? '0 : cntr_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        load     = !fifo_empty;
      end
      S_START: begin
        if (bit_end) begin
          serial_d = shift_q[0];
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bitcntr_q == LAST_BIT) begin
            serial_d  = 1'b1;
            bitcntr_d = '0;
            state_d   = S_STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            serial_d  = shift_q[1];
            bitcntr_d = bitcntr_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            serial_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading a frame snapshots the bit period so later UART_CPB writes wait for the next frame.
    if (load) begin
      shift_d   = fifo_dout;
      cpb_d     = UART_CPB;
      cntr_d    = '0;
      bitcntr_d = '0;
      serial_d  = 1'b0;
      state_d   = S_START;
    end
  end

  assign tx_full   = fifo_full;
  assign tx_busy   = (state_q != S_IDLE) || !fifo_empty;
  assign tx_serial = serial_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: every cycle is compared against a queue-based frame model.
module tb_uart_tx;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [15:0] UART_CPB;
  logic [7:0]  UART_TDR;
  logic        tx_wr;
  logic        tx_full;
  logic        tx_busy;
  logic        tx_serial;
  logic        tx_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic       lineQ[$];
  logic [7:0] fifoQ[$];
  int         doneQ[$];
  logic       expDone = 1'b0;

  typedef struct {
    logic [15:0] cpb;
    logic [7:0]  data;
    logic [9:0]  expBits;
  } vec_t;

  vec_t vecs[6];
  logic lineSamples[0:199];

  uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .UART_CPB  (UART_CPB),
    .UART_TDR  (UART_TDR),
    .tx_wr     (tx_wr),
    .tx_full   (tx_full),
    .tx_busy   (tx_busy),
    .tx_serial (tx_serial),
    .tx_done   (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] cpb, input logic [7:0] data, input logic wr);
    UART_CPB = cpb;
    UART_TDR = data;
    tx_wr    = wr;
  endtask

  // A frame is the start bit, the data LSB first and the stop bit, each held cpb+1 cycles.
  task automatic buildFrame(input logic [7:0] b, input logic [15:0] cpb);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int r = 0; r <= int'(cpb); r++)
        lineQ.push_back(bits[k]);
  endtask

  task automatic modelStep();
    int preSize;
    logic [7:0] head;
    preSize = fifoQ.size();
    expDone = 1'b0;
    if (!rst) begin
      lineQ.delete();
      fifoQ.delete();
    end else begin
      if (lineQ.size() != 0) begin
        lineQ.delete(0);
        if (lineQ.size() == 0) expDone = 1'b1;
      end
      if (lineQ.size() == 0 && preSize != 0) begin
        head = fifoQ.pop_front();
        buildFrame(head, UART_CPB);
      end
      if (tx_wr && preSize < DEPTH) fifoQ.push_back(UART_TDR);
    end
  endtask

  task automatic checkModel();
    logic expSerial;
    expSerial = (lineQ.size() != 0) ? lineQ[0] : 1'b1;
    checkOutput("serial", tx_serial, expSerial);
    checkOutput("done", tx_done, expDone);
    checkOutput("full", tx_full, fifoQ.size() == DEPTH);
    checkOutput("busy", tx_busy, (lineQ.size() != 0) || (fifoQ.size() != 0));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    cyc++;
    checkModel();
    if (tx_done === 1'b1) doneQ.push_back(cyc);
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    checkOutput("wait_idle", tx_busy, 1'b0);
  endtask

  initial begin
    int t0;
    int bitLen;
    int doneAt;
    int badCnt;
    logic sawLow;

    rst = 1'b0;
    applyStimulus(16'd0, 8'h00, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkOutput("reset_serial", tx_serial, 1'b1);
    checkOutput("reset_done", tx_done, 1'b0);
    checkOutput("reset_busy", tx_busy, 1'b0);
    checkOutput("reset_full", tx_full, 1'b0);

    vecs[0] = '{16'd3, 8'hA5, 10'b1101001010};
    vecs[1] = '{16'd0, 8'h00, 10'b1000000000};
    vecs[2] = '{16'd1, 8'hFF, 10'b1111111110};
    vecs[3] = '{16'd2, 8'h3C, 10'b1001111000};
    vecs[4] = '{16'd5, 8'hC3, 10'b1110000110};
    vecs[5] = '{16'd0, 8'h81, 10'b1100000010};

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].cpb, vecs[v].data, 1'b1);
      tick();
      applyStimulus(vecs[v].cpb, vecs[v].data, 1'b0);
      bitLen = int'(vecs[v].cpb) + 1;
      doneAt = -1;
      for (int c = 0; c <= 10 * bitLen; c++) begin
        tick();
        if (c < 10 * bitLen) lineSamples[c] = tx_serial;
        if (tx_done === 1'b1 && doneAt < 0) doneAt = c;
      end
      for (int k = 0; k < 10; k++) begin
        badCnt = 0;
        for (int r = 0; r < bitLen; r++)
          if (lineSamples[k * bitLen + r] !== vecs[v].expBits[k]) badCnt++;
        checkOutput($sformatf("vec%0d_bit%0d_bad_cycles", v, k), badCnt, 0);
      end
      checkOutput($sformatf("vec%0d_done_at", v), doneAt, 10 * bitLen);
      waitIdle(20);
      repeat (2) tick();
    end

    // Back to back: three frames of 160 cycles with no idle gap.
    doneQ.delete();
    applyStimulus(16'd15, 8'h00, 1'b1);
    tick();
    applyStimulus(16'd15, 8'hFF, 1'b1);
    tick();
    t0 = cyc;
    applyStimulus(16'd15, 8'h5A, 1'b1);
    tick();
    applyStimulus(16'd15, 8'h00, 1'b0);
    repeat (490) tick();
    checkOutput("b2b_done_count", doneQ.size(), 3);
    if (doneQ.size() == 3) begin
      checkOutput("b2b_done0", doneQ[0] - t0, 160);
      checkOutput("b2b_done1", doneQ[1] - t0, 320);
      checkOutput("b2b_done2", doneQ[2] - t0, 480);
    end
    waitIdle(20);

    // Overflow: the fifth accepted write fills the FIFO, later writes are dropped.
    doneQ.delete();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(16'd7, 8'(i), 1'b1);
      tick();
      checkOutput($sformatf("ovf_full_after_write%0d", i), tx_full, i >= 5);
    end
    applyStimulus(16'd7, 8'h00, 1'b0);
    repeat (420) tick();
    checkOutput("ovf_done_count", doneQ.size(), 5);
    waitIdle(20);

    // Bit period change mid-frame applies only to the following frame.
    doneQ.delete();
    applyStimulus(16'd3, 8'h5A, 1'b1);
    tick();
    applyStimulus(16'd3, 8'h96, 1'b1);
    tick();
    t0 = cyc;
    applyStimulus(16'd3, 8'h00, 1'b0);
    repeat (10) tick();
    UART_CPB = 16'd9;
    repeat (140) tick();
    checkOutput("cpb_done_count", doneQ.size(), 2);
    if (doneQ.size() == 2) begin
      checkOutput("cpb_frame1_done", doneQ[0] - t0, 40);
      checkOutput("cpb_frame2_done", doneQ[1] - t0, 140);
    end
    waitIdle(20);

    // Reset during data bit 3 with two bytes still queued.
    applyStimulus(16'd3, 8'h81, 1'b1);
    tick();
    t0 = cyc;
    applyStimulus(16'd3, 8'h11, 1'b1);
    tick();
    applyStimulus(16'd3, 8'h22, 1'b1);
    tick();
    applyStimulus(16'd3, 8'h00, 1'b0);
    while (cyc - t0 < 17) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checkOutput("rst_mid_serial", tx_serial, 1'b1);
    checkOutput("rst_mid_busy", tx_busy, 1'b0);
    checkOutput("rst_mid_full", tx_full, 1'b0);
    doneQ.delete();
    sawLow = 1'b0;
    repeat (100) begin
      tick();
      if (tx_serial !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("rst_mid_line_quiet", sawLow, 1'b0);
    checkOutput("rst_mid_no_done", doneQ.size(), 0);

    // Random traffic with occasional bit-period changes and resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) UART_CPB = 16'($urandom_range(0, 3));
      UART_TDR = 8'($urandom);
      tx_wr    = ($urandom_range(0, 9) < 3);
      rst      = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst   = 1'b1;
    tx_wr = 1'b0;
    waitIdle(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
